// File: rtl/fwrisc_mem_arbiter.sv
// Shares one memory bus between the fwrisc fetch and data ports; holds the grant until mready.
// Define FWRISC_MEM_ARB_RR_EN for round-robin arbitration instead of data priority with a starvation guard.
module fwrisc_mem_arbiter #(
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        ivalid,
   input  logic [31:0] iaddr,
   output logic        iready,
   output logic [31:0] idata,
   input  logic        dvalid,
   input  logic [31:0] daddr,
   input  logic [31:0] dwdata,
   input  logic [3:0]  dwstb,
   input  logic        dwrite,
   output logic        dready,
   output logic [31:0] drdata,
   output logic        mvalid,
   output logic [31:0] maddr,
   output logic [31:0] mwdata,
   output logic [3:0]  mwstb,
   output logic        mwrite,
   input  logic        mready,
   input  logic [31:0] mrdata,
   output logic        owner,
   output logic        busy
);
   typedef enum logic [1:0] {IDLE = 2'd0, BUSY_I = 2'd1, BUSY_D = 2'd2} state_e;

   state_e      state_q, state_d;
   logic        mvalid_q, mvalid_d;
   logic        busy_q, busy_d;
   logic        owner_q, owner_d;
   logic        mwrite_q, mwrite_d;
   logic [31:0] maddr_q, maddr_d;
   logic [31:0] mwdata_q, mwdata_d;
   logic [3:0]  mwstb_q, mwstb_d;
   logic        pick_d;

`ifdef FWRISC_MEM_ARB_RR_EN
   logic        last_owner_q, last_owner_d;

   // On a tie the side that did not win last time goes next.
   always_comb pick_d = dvalid & (~ivalid | ~last_owner_q);
`else
   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
   logic [3:0]  starve_cnt_q, starve_cnt_d;

   always_comb pick_d = dvalid & ~(ivalid & (starve_cnt_q == STARVE_LIM));
`endif

   always_comb begin
      state_d  = state_q;
      mvalid_d = mvalid_q;
      busy_d   = busy_q;
      owner_d  = owner_q;
      mwrite_d = mwrite_q;
      maddr_d  = maddr_q;
      mwdata_d = mwdata_q;
      mwstb_d  = mwstb_q;
`ifdef FWRISC_MEM_ARB_RR_EN
      last_owner_d = last_owner_q;
`else
      starve_cnt_d = starve_cnt_q;
`endif
      case (state_q)
         IDLE: begin
            if (ivalid | dvalid) begin
               mvalid_d = 1'b1;
               busy_d   = 1'b1;
               owner_d  = pick_d;
               if (pick_d) begin
                  state_d  = BUSY_D;
                  maddr_d  = daddr;
                  mwdata_d = dwdata;
                  mwstb_d  = dwstb;
                  mwrite_d = dwrite;
               end else begin
                  state_d  = BUSY_I;
                  maddr_d  = iaddr;
                  mwdata_d = '0;
                  mwstb_d  = 4'hF;
                  mwrite_d = 1'b0;
               end
`ifdef FWRISC_MEM_ARB_RR_EN
               last_owner_d = pick_d;
`else
               if (!pick_d)
                  starve_cnt_d = '0;
               else if (ivalid)
                  starve_cnt_d = starve_cnt_q + 4'd1;
`endif
            end
         end
         BUSY_I, BUSY_D: begin
            if (mready) begin
               state_d  = IDLE;
               mvalid_d = 1'b0;
               busy_d   = 1'b0;
            end
         end
         default: begin
            state_d  = IDLE;
            mvalid_d = 1'b0;
            busy_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= IDLE;
         mvalid_q <= 1'b0;
         busy_q   <= 1'b0;
         owner_q  <= 1'b0;
         mwrite_q <= 1'b0;
         maddr_q  <= '0;
         mwdata_q <= '0;
         mwstb_q  <= '0;
`ifdef FWRISC_MEM_ARB_RR_EN
         last_owner_q <= 1'b1;
`else
         starve_cnt_q <= '0;
`endif
      end else begin
         state_q  <= state_d;
         mvalid_q <= mvalid_d;
         busy_q   <= busy_d;
         owner_q  <= owner_d;
         mwrite_q <= mwrite_d;
         maddr_q  <= maddr_d;
         mwdata_q <= mwdata_d;
         mwstb_q  <= mwstb_d;
`ifdef FWRISC_MEM_ARB_RR_EN
         last_owner_q <= last_owner_d;
`else
         starve_cnt_q <= starve_cnt_d;
`endif
      end
   end

   // Ready is gated by reset so an abort never leaks a completion.
   assign iready = ~reset & (state_q == BUSY_I) & mready;
   assign dready = ~reset & (state_q == BUSY_D) & mready;
   assign idata  = mrdata;
   assign drdata = mrdata;
   assign mvalid = mvalid_q;
   assign maddr  = maddr_q;
   assign mwdata = mwdata_q;
   assign mwstb  = mwstb_q;
   assign mwrite = mwrite_q;
   assign owner  = owner_q;
   assign busy   = busy_q;
endmodule
